// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - round-robin sequencer sharing one accumulator ALU; optional ALU_SEQ_CTX_EN per-requester context
module alu_op_sequencer #(
    parameter int DATA_W  = 4,
    parameter int OP_W    = 2,
    parameter int NUM_REQ = 2
) (
    input  logic                      clk,
    input  logic                      RESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_opnd,
    input  logic [NUM_REQ-1:0]        req_clr,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [DATA_W-1:0]         alu_a,
    output logic [OP_W-1:0]           alu_inst,
    output logic                      alu_rst,
    input  logic [DATA_W-1:0]         alu_out,
    output logic                      busy
);

`ifdef ALU_SEQ_CTX_EN
    typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD, S_EXEC, S_WB, S_RESP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_CLR, S_EXEC, S_WB, S_RESP} state_t;
`endif

    state_t              state;
    logic                last;
    logic                cur_id;
    logic [OP_W-1:0]     cur_op;
    logic [DATA_W-1:0]   cur_opnd;
    logic                grant_any;
    logic                grant_id;
`ifdef ALU_SEQ_CTX_EN
    logic                cur_clr;
    logic [DATA_W-1:0]   ctx [NUM_REQ];
`endif

    // With both requesting, the one not served last wins; otherwise whoever asks.
    always_comb begin
        grant_id = req_valid[1];
        if (req_valid[0] && req_valid[1]) begin
            grant_id = ~last;
        end
    end

    assign grant_any = (state == S_IDLE) && (|req_valid);

    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            last      <= 1'b1;
            cur_id    <= 1'b0;
            cur_op    <= '0;
            cur_opnd  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
`ifdef ALU_SEQ_CTX_EN
            cur_clr   <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                ctx[i] <= '0;
            end
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        last     <= grant_id;
                        cur_id   <= grant_id;
                        cur_op   <= req_op[grant_id*OP_W +: OP_W];
                        cur_opnd <= req_opnd[grant_id*DATA_W +: DATA_W];
`ifdef ALU_SEQ_CTX_EN
                        cur_clr  <= req_clr[grant_id];
                        state    <= S_CLR;
`else
                        state    <= req_clr[grant_id] ? S_CLR : S_EXEC;
`endif
                    end
                end
                S_CLR: begin
`ifdef ALU_SEQ_CTX_EN
                    // A cleared context is already what the accumulator holds.
                    state <= cur_clr ? S_EXEC : S_LOAD;
`else
                    state <= S_EXEC;
`endif
                end
`ifdef ALU_SEQ_CTX_EN
                S_LOAD: state <= S_EXEC;
`endif
                S_EXEC: state <= S_WB;
                S_WB: begin
                    rsp_data <= alu_out;
                    rsp_id   <= cur_id;
`ifdef ALU_SEQ_CTX_EN
                    ctx[cur_id] <= alu_out;
`endif
                    state    <= S_RESP;
                end
                S_RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The ALU clocks every cycle, so every other state must present add-0.
    always_comb begin
        alu_a    = '0;
        alu_inst = '0;
        case (state)
            S_EXEC: begin
                alu_a    = cur_opnd;
                alu_inst = cur_op;
            end
`ifdef ALU_SEQ_CTX_EN
            S_LOAD: alu_a = ctx[cur_id];
`endif
            default: ;
        endcase
    end

    assign alu_rst = RESET | (state == S_CLR);
    assign busy    = (state != S_IDLE);

endmodule
